hex_scroll_ctrl: RTL and testbench
==================================

Name: hex_scroll_ctrl

Overview:
Message buffer and scroll sequencer for the eight-digit seven-segment marquee on the DE2 board. Stores up to 16 active-low segment patterns and generates its own step tick from CLOCK_50. Each step, the message advances one digit from HEX7 toward HEX0, with blank lead-in and lead-out frames. Sits directly upstream of the HEX pin drivers. Replaces hard-coded per-frame case tables with a programmable window.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
STEP_HZ, 1, scroll step rate in Hz; the prescaler terminal count is CLK_HZ/STEP_HZ-1, and CLK_HZ/STEP_HZ must be at least 2
MAX_LEN, 16, buffer depth in characters, fixed at 16 so that address and length widths stay as given below

Ports:
CLOCK_50  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe, one entry per cycle
wr_addr  in  4  buffer index 0..15, where index 0 is the first character of the message
wr_data  in  7  segment pattern {g,f,e,d,c,b,a}, active-low (7'h7F = blank, 7'h3F = '-')
msg_len  in  5  active message length, 0..16; values above 16 are treated as 16
run  in  1  1 = scroll, 0 = freeze the current frame
dir  in  1  0 = forward (text enters at HEX7 and exits at HEX0), 1 = reverse
step_tick  out  1  one-cycle pulse at the prescaler terminal count
wrap  out  1  one-cycle pulse when the frame counter wraps in either direction
HEX7..HEX0  out  7 each  registered segment outputs, active-low

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - Prescaler = 0, frame f = 0, step_tick = 0, wrap = 0.
  - All 16 buffer entries = 7'h7F.
  - All HEX outputs = 7'h7F.
- Prescaler:
  - Counts 0..CLK_HZ/STEP_HZ-1 while run=1. step_tick=1 for the single cycle in which the count is at its terminal value; the count returns to 0 on the next clock.
  - run=0 clears the prescaler to 0 and holds it there. When run rises, the first tick occurs exactly CLK_HZ/STEP_HZ cycles later.
- Frame counter:
  - L = min(msg_len, 16). Frame range is 0..L+7, giving L+8 frames.
  - On step_tick with dir=0: f wraps from L+7 to 0, otherwise increments.
  - On step_tick with dir=1: f wraps from 0 to L+7, otherwise decrements.
  - wrap is registered alongside f and is high for the one cycle in which the wrapped value of f first appears.
  - L=0: f is held at 0, wrap never fires, all digits are blank.
  - Shrinking msg_len while f > L+7: at the next step_tick, f loads 0 (dir=0) or L+7 (dir=1), and wrap fires.
- Digit mapping:
  - Digit position d: HEX7 is d=0, HEX0 is d=7.
  - Index i = L - f + d.
  - If 0 <= i < L, digit d shows buf[i]; otherwise it shows 7'h7F.
  - Example, L=6, buffer "-FPGA-":
    - f=0: all digits blank.
    - f=1: HEX7 = buf[5].
    - f=6: HEX7..HEX2 read "-FPGA-".
    - f=13: HEX0 = buf[0], all other digits blank.
- Output timing:
  - HEX outputs are registered from the current f and buffer contents every clock, so each output lags its inputs by exactly one cycle.
  - A frame advance is visible on HEX one cycle after the cycle in which the new f is registered.
  - A buffer write is visible on HEX one cycle after the write edge.
- Writes:
  - Accepted in any state, including while scrolling.
  - A write to an index that is not displayed has no visible effect.
  - A write takes effect at the clock edge where wr_en=1.
- Simultaneous events:
  - A write and a step_tick in the same cycle are both applied; HEX reflects both one cycle later.
  - Changing dir in the step_tick cycle: the new value of dir governs that step.
- Reset asserted mid-scroll returns the block to the reset state immediately. The buffer contents are lost.

Test Plan:
Bench parameters: CLK_HZ=10, STEP_HZ=1, so one step every 10 cycles.
1. Reset: hold RESET_N low, write "-FPGA-" to indices 0..5, msg_len=6, run=1, release reset -> all HEX = 7'h7F, f=0. The writes made during reset are ignored and the buffer stays blank.
2. Forward scroll: after reset, write 7'h3F,7'h0E,7'h0C,7'h42,7'h08,7'h3F to indices 0..5, msg_len=6, run=1, dir=0 -> step_tick every 10 cycles. f=1 gives HEX7=7'h3F. f=6 gives HEX7..HEX2 = 3F,0E,0C,42,08,3F. f=13 gives HEX0 = 7'h3F with all other digits blank. After 14 ticks, f=0 with wrap high for 1 cycle.
3. Freeze and reverse: at f=4, set run=0 for 50 cycles -> no step_tick and HEX unchanged. Then set run=1, dir=1 -> the first tick arrives 10 cycles later and f goes to 3. Continue to f=0; the next tick gives f=13 and wrap=1.
4. Live write: while scrolling at f=6, write wr_addr=2, wr_data=7'h7F -> one cycle later HEX5 = 7'h7F and all other digits are unchanged.
5. Length shrink: at f=12 with L=6, change msg_len to 2 -> at the next tick f=0 and wrap=1. With msg_len=0, all HEX = 7'h7F and wrap never fires over 100 ticks.
6. Mid-scroll reset: pulse RESET_N low for 1 cycle at f=9 -> HEX = 7'h7F immediately, f=0, buffer cleared. With run=1, the next tick moves f to 1 while all digits remain 7'h7F.

Source files
------------

// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: 16-entry segment buffer plus a self-timed scroll
// sequencer for the eight-digit seven-segment marquee. Each step moves the
// message one digit from HEX7 toward HEX0 (or back when dir=1), with blank
// lead-in and lead-out frames on either side of the text.
module hex_scroll_ctrl #(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 1,
  parameter int MAX_LEN = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       run,
  input  logic       dir,
  output logic       step_tick,
  output logic       wrap,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int          DIV     = CLK_HZ / STEP_HZ;
  localparam int          PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC    = PW'(DIV - 1);
  localparam logic [4:0]  LEN_MAX = 5'(MAX_LEN);
  localparam logic [6:0]  BLANK   = 7'h7F;

  logic [PW-1:0] r_presc;
  logic [4:0]    r_f;
  logic          r_wrap;
  logic [6:0]    r_buf [16];
  logic [6:0]    r_hex [8];

  logic          w_tick;
  logic [4:0]    w_len;
  logic [4:0]    w_last;
  logic [4:0]    w_f_next;
  logic          w_wrap_next;
  logic [6:0]    w_digit [8];

  // Tick only while running, so a freeze can never let a step slip through.
  assign w_tick    = run && (r_presc == TC);
  assign step_tick = w_tick;
  assign wrap      = r_wrap;

  // Clamp the length: anything above the buffer depth behaves as a full buffer.
  assign w_len  = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign w_last = w_len + 5'd7;

  // Step-rate prescaler: cleared and held while frozen, free-running otherwise.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc <= '0;
    end else if (!run || r_presc == TC) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Next frame and wrap strobe; an out-of-range frame (after a length shrink)
  // snaps to the start of the new range and counts as a wrap.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch behind.
    w_f_next    = r_f;
    w_wrap_next = 1'b0;
    if (w_tick) begin
      if (w_len == 5'd0) begin
        w_f_next = 5'd0;
      end else if (!dir) begin
        if (r_f >= w_last) begin
          w_f_next    = 5'd0;
          w_wrap_next = 1'b1;
        end else begin
          w_f_next = r_f + 5'd1;
        end
      end else begin
        if (r_f == 5'd0 || r_f > w_last) begin
          w_f_next    = w_last;
          w_wrap_next = 1'b1;
        end else begin
          w_f_next = r_f - 5'd1;
        end
      end
    end
  end

  // Frame counter and its wrap pulse, registered together.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_f    <= 5'd0;
      r_wrap <= 1'b0;
    end else begin
      r_f    <= w_f_next;
      r_wrap <= w_wrap_next;
    end
  end

  // Message buffer; writes are accepted at any time, including mid-scroll.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the buffer is deliberately reset so a fresh message starts from blanks; this forces flops, not RAM.
      for (int i = 0; i < 16; i++) r_buf[i] <= BLANK;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Window mapping: digit d (HEX7 = 0) shows character L - f + d when that
  // index falls inside the message, blank otherwise.
  always_comb begin
    logic signed [6:0] idx;
    idx = '0;
    for (int d = 0; d < 8; d++) begin
      w_digit[d] = BLANK;
      idx = $signed({2'b00, w_len}) - $signed({2'b00, r_f}) + $signed(7'(d));
      if (idx >= 7'sd0 && idx < $signed({2'b00, w_len})) begin
        w_digit[d] = r_buf[idx[3:0]];
      end
    end
  end

  // Output registers feeding the HEX pin drivers directly.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int d = 0; d < 8; d++) r_hex[d] <= BLANK;
    end else begin
      for (int d = 0; d < 8; d++) r_hex[d] <= w_digit[d];
    end
  end

  assign HEX7 = r_hex[0];
  assign HEX6 = r_hex[1];
  assign HEX5 = r_hex[2];
  assign HEX4 = r_hex[3];
  assign HEX3 = r_hex[4];
  assign HEX2 = r_hex[5];
  assign HEX1 = r_hex[6];
  assign HEX0 = r_hex[7];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a 10-cycle step period.
module tb_hex_scroll_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       wr_en    = 1'b0;
  logic [3:0] wr_addr  = '0;
  logic [6:0] wr_data  = '0;
  logic [4:0] msg_len  = '0;
  logic       run      = 1'b0;
  logic       dir      = 1'b0;
  logic       step_tick, wrap;
  logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [55:0] hex_bus;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected frames as {HEX7 .. HEX0}, worked out by hand for L = 6 and the
  // message 3F,0E,0C,42,08,3F (index i = L - f + d).
  localparam logic [55:0] BLANK = {8{7'h7F}};
  localparam logic [55:0] F1  = {7'h3F, {7{7'h7F}}};
  localparam logic [55:0] F2  = {7'h08, 7'h3F, {6{7'h7F}}};
  localparam logic [55:0] F3  = {7'h42, 7'h08, 7'h3F, {5{7'h7F}}};
  localparam logic [55:0] F4  = {7'h0C, 7'h42, 7'h08, 7'h3F, {4{7'h7F}}};
  localparam logic [55:0] F6  = {7'h3F, 7'h0E, 7'h0C, 7'h42, 7'h08, 7'h3F, 7'h7F, 7'h7F};
  localparam logic [55:0] F13 = {{7{7'h7F}}, 7'h3F};
  // After buf[2] is overwritten with blank.
  localparam logic [55:0] F6W = {7'h3F, 7'h0E, 7'h7F, 7'h42, 7'h08, 7'h3F, 7'h7F, 7'h7F};
  localparam logic [55:0] F12 = {{6{7'h7F}}, 7'h3F, 7'h0E};
  localparam logic [55:0] F9W = {{3{7'h7F}}, 7'h3F, 7'h0E, 7'h7F, 7'h42, 7'h08};

  hex_scroll_ctrl #(.CLK_HZ(10), .STEP_HZ(1), .MAX_LEN(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .run      (run),
    .dir      (dir),
    .step_tick(step_tick),
    .wrap     (wrap),
    .HEX7     (HEX7),
    .HEX6     (HEX6),
    .HEX5     (HEX5),
    .HEX4     (HEX4),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX1     (HEX1),
    .HEX0     (HEX0)
  );

  assign hex_bus = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Wait for the next step_tick (bounded), then move two cycles on so the
  // new frame is on HEX. Returns the wrap seen in the cycle the new frame
  // was registered and the number of negedges spent reaching the tick.
  task automatic step(output logic w, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLOCK_50);
      cyc++;
    end while (step_tick !== 1'b1 && cyc < 30);
    n_tests++;
    if (step_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL step_timeout: step_tick=%b after %0d cycles, required 1", step_tick, cyc);
    end
    @(negedge CLOCK_50);
    w = wrap;
    n_tests++;
    if (step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_width: step_tick=%b, required 0", step_tick);
    end
    @(negedge CLOCK_50);
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_width: wrap=%b, required 0", wrap);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    wr_en = 1'b0;
    run = 1'b0;
    dir = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  task automatic write(input logic [3:0] a, input logic [6:0] d);
    @(negedge CLOCK_50);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic w;
    int c;
    logic [6:0] msg [6] = '{7'h3F, 7'h0E, 7'h0C, 7'h42, 7'h08, 7'h3F};
    RESET_N = 1'b0;
    run = 1'b1;
    msg_len = 5'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = msg[i];
    end
    @(negedge CLOCK_50);
    wr_en = 1'b0;
    n_tests++;
    if (hex_bus !== BLANK || step_tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: hex=%h tick=%b wrap=%b, required %h 0 0", hex_bus, step_tick, wrap, BLANK);
    end
    RESET_N = 1'b1;
    step(w, c);
    n_tests++;
    if (c !== 9) begin
      n_fail++;
      $display("FAIL reset_first_tick: %0d cycles, required 9", c);
    end
    // Frames 1..6 would expose any write that slipped in during reset.
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step(w, c);
      n_tests++;
      if (hex_bus !== BLANK) begin
        n_fail++;
        $display("FAIL reset_writes_ignored f=%0d: hex=%h, required %h", k, hex_bus, BLANK);
      end
    end
  endtask

  task automatic test_forward();
    logic w;
    int c;
    logic [6:0] msg [6] = '{7'h3F, 7'h0E, 7'h0C, 7'h42, 7'h08, 7'h3F};
    do_reset();
    for (int i = 0; i < 6; i++) write(4'(i), msg[i]);
    msg_len = 5'd6;
    run = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(w, c);
      n_tests++;
      if (w !== (k == 14)) begin
        n_fail++;
        $display("FAIL fwd_wrap step %0d: wrap=%b, required %b", k, w, (k == 14));
      end
      if (k == 1 || k == 2 || k == 6 || k == 13 || k == 14) begin
        logic [55:0] exp;
        exp = (k == 1) ? F1 : (k == 2) ? F2 : (k == 6) ? F6 : (k == 13) ? F13 : BLANK;
        n_tests++;
        if (hex_bus !== exp) begin
          n_fail++;
          $display("FAIL fwd_frame step %0d: hex=%h, required %h", k, hex_bus, exp);
        end
      end
    end
  endtask

  task automatic test_freeze_reverse();
    logic w;
    int c;
    logic saw_tick = 1'b0;
    logic saw_change = 1'b0;
    for (int k = 1; k <= 4; k++) step(w, c);
    n_tests++;
    if (hex_bus !== F4) begin
      n_fail++;
      $display("FAIL f4_frame: hex=%h, required %h", hex_bus, F4);
    end
    run = 1'b0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if (step_tick !== 1'b0) saw_tick = 1'b1;
      if (hex_bus !== F4) saw_change = 1'b1;
    end
    n_tests++;
    if (saw_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_tick: tick seen=%b, required 0", saw_tick);
    end
    n_tests++;
    if (saw_change !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_hex: change seen=%b, required 0", saw_change);
    end
    run = 1'b1;
    dir = 1'b1;
    step(w, c);
    n_tests++;
    if (c !== 9 || hex_bus !== F3 || w !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_first: cycles=%0d hex=%h wrap=%b, required 9 %h 0", c, hex_bus, w, F3);
    end
    for (int k = 2; k >= 0; k--) begin
      step(w, c);
      n_tests++;
      if (w !== 1'b0) begin
        n_fail++;
        $display("FAIL rev_wrap f=%0d: wrap=%b, required 0", k, w);
      end
    end
    n_tests++;
    if (hex_bus !== BLANK) begin
      n_fail++;
      $display("FAIL rev_f0: hex=%h, required %h", hex_bus, BLANK);
    end
    step(w, c);
    n_tests++;
    if (w !== 1'b1 || hex_bus !== F13) begin
      n_fail++;
      $display("FAIL rev_wrap_13: wrap=%b hex=%h, required 1 %h", w, hex_bus, F13);
    end
  endtask

  task automatic test_live_write();
    logic w;
    int c;
    dir = 1'b0;
    step(w, c);
    n_tests++;
    if (w !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_from_13_wrap: wrap=%b, required 1", w);
    end
    for (int k = 1; k <= 6; k++) step(w, c);
    n_tests++;
    if (hex_bus !== F6) begin
      n_fail++;
      $display("FAIL live_pre: hex=%h, required %h", hex_bus, F6);
    end
    @(negedge CLOCK_50);
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_data = 7'h7F;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
    n_tests++;
    if (hex_bus !== F6) begin
      n_fail++;
      $display("FAIL live_lag: hex=%h, required %h", hex_bus, F6);
    end
    @(negedge CLOCK_50);
    n_tests++;
    if (hex_bus !== F6W) begin
      n_fail++;
      $display("FAIL live_write: hex=%h, required %h", hex_bus, F6W);
    end
  endtask

  task automatic test_shrink();
    logic w;
    int c;
    int ticks = 0;
    logic saw_wrap = 1'b0;
    logic saw_lit = 1'b0;
    for (int k = 7; k <= 12; k++) step(w, c);
    n_tests++;
    if (hex_bus !== F12) begin
      n_fail++;
      $display("FAIL f12_frame: hex=%h, required %h", hex_bus, F12);
    end
    msg_len = 5'd2;
    step(w, c);
    n_tests++;
    if (w !== 1'b1 || hex_bus !== BLANK) begin
      n_fail++;
      $display("FAIL shrink_wrap: wrap=%b hex=%h, required 1 %h", w, hex_bus, BLANK);
    end
    msg_len = 5'd0;
    repeat (1000) begin
      @(negedge CLOCK_50);
      if (step_tick === 1'b1) ticks++;
      if (wrap !== 1'b0) saw_wrap = 1'b1;
      if (hex_bus !== BLANK) saw_lit = 1'b1;
    end
    n_tests++;
    if (ticks !== 100) begin
      n_fail++;
      $display("FAIL len0_ticks: %0d ticks, required 100", ticks);
    end
    n_tests++;
    if (saw_wrap !== 1'b0 || saw_lit !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_quiet: wrap seen=%b lit seen=%b, required 0 0", saw_wrap, saw_lit);
    end
  endtask

  task automatic test_mid_reset();
    logic w;
    int c;
    msg_len = 5'd6;
    for (int k = 1; k <= 9; k++) step(w, c);
    n_tests++;
    if (hex_bus !== F9W) begin
      n_fail++;
      $display("FAIL f9_frame: hex=%h, required %h", hex_bus, F9W);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    n_tests++;
    if (hex_bus !== BLANK || wrap !== 1'b0 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: hex=%h wrap=%b tick=%b, required %h 0 0", hex_bus, wrap, step_tick, BLANK);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step(w, c);
    n_tests++;
    if (c !== 9 || w !== 1'b0 || hex_bus !== BLANK) begin
      n_fail++;
      $display("FAIL post_reset_step: cycles=%0d wrap=%b hex=%h, required 9 0 %h", c, w, hex_bus, BLANK);
    end
    // Lighting buf[5] alone proves both f = 1 and that the rest was cleared.
    write(4'd5, 7'h3F);
    @(negedge CLOCK_50);
    n_tests++;
    if (hex_bus !== F1) begin
      n_fail++;
      $display("FAIL post_reset_f1: hex=%h, required %h", hex_bus, F1);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_freeze_reverse();
    test_live_write();
    test_shrink();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
